// File: rtl/timer_ctrl.sv
// timer_ctrl: configurable up-counter timer with one-shot / auto-reload modes,
// a level-sensitive hold, an abort (stop) request and a valid/ready config port.
module timer_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic             cfg_periodic,
  input  logic             start,
  input  logic             hold,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tick,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] LIM_DFLT = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             periodic_q, periodic_d;
  logic             done_q, done_d;
  logic             at_limit;

  // Terminal-count compare shared by tick and the next-state logic.
  assign at_limit = (count_q == limit_q);

  // State, counter, configuration and done registers; reset restores defaults.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= CNT_ZERO;
      limit_q    <= LIM_DFLT;
      periodic_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      limit_q    <= limit_d;
      periodic_q <= periodic_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic. Priority while busy: stop, then hold, then counting.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    limit_d    = limit_q;
    periodic_d = periodic_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A config arriving on the same edge as start governs that run,
        // because the run reads limit_q/periodic_q only from the next cycle.
        if (cfg_valid) begin
          limit_d    = cfg_limit;
          periodic_d = cfg_periodic;
        end
        if (start) begin
          state_d = RUN;
          count_d = CNT_ZERO;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          count_d = CNT_ZERO;
        end else if (hold) begin
          state_d = HOLD;
        end else if (at_limit) begin
          if (periodic_q) begin
            count_d = CNT_ZERO;
          end else begin
            // One-shot completion: count stays at the limit for inspection.
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end
      HOLD: begin
        if (stop) begin
          state_d = IDLE;
          count_d = CNT_ZERO;
        end else if (!hold) begin
          // Resume without advancing; counting restarts on the following edge.
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = CNT_ZERO;
      end
    endcase
  end

  assign cfg_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign tick      = (state_q == RUN) && at_limit;
  assign count     = count_q;
  assign done      = done_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed self-checking bench for timer_ctrl (WIDTH = 4).
// Observed vector layout: {busy, cfg_ready, tick, done, count[3:0]}.
module tb_timer_ctrl;

  logic       clk;
  logic       reset;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [3:0] cfg_limit;
  logic       cfg_periodic;
  logic       start;
  logic       hold;
  logic       stop;
  logic [3:0] count;
  logic       busy;
  logic       tick;
  logic       done;

  logic [7:0] obs;
  logic [7:0] exp_v;
  int         pass_cnt;
  int         total;

  timer_ctrl #(.WIDTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_limit    (cfg_limit),
    .cfg_periodic (cfg_periodic),
    .start        (start),
    .hold         (hold),
    .stop         (stop),
    .count        (count),
    .busy         (busy),
    .tick         (tick),
    .done         (done)
  );

  assign obs = {busy, cfg_ready, tick, done, count};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input logic [3:0] lim, input logic per);
    cfg_valid    = 1'b1;
    cfg_limit    = lim;
    cfg_periodic = per;
    step();
    cfg_valid    = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++;
    exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
    if (obs !== exp_v) $display("FAIL reset_async obs=%b exp=%b", obs, exp_v);
    else pass_cnt++;
    start = 1'b1;
    step();
    step();
    total++;
    if (obs !== exp_v) $display("FAIL reset_held obs=%b exp=%b", obs, exp_v);
    else pass_cnt++;
    start = 1'b0;
    reset = 1'b0;
    step();
    // stop in IDLE is ignored
    stop = 1'b1;
    step();
    stop = 1'b0;
    total++;
    if (obs !== exp_v) $display("FAIL stop_in_idle obs=%b exp=%b", obs, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_oneshot();
    configure(4'd3, 1'b0);
    do_start();
    for (int i = 0; i < 4; i++) begin
      total++;
      exp_v = {1'b1, 1'b0, (i == 3), 1'b0, 4'(i)};
      if (obs !== exp_v) $display("FAIL oneshot_run[%0d] obs=%b exp=%b", i, obs, exp_v);
      else pass_cnt++;
      step();
    end
    total++;
    exp_v = {1'b0, 1'b1, 1'b0, 1'b1, 4'd3};
    if (obs !== exp_v) $display("FAIL oneshot_done obs=%b exp=%b", obs, exp_v);
    else pass_cnt++;
    step();
    total++;
    exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 4'd3};
    if (obs !== exp_v) $display("FAIL oneshot_after obs=%b exp=%b", obs, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_periodic();
    configure(4'd2, 1'b1);
    do_start();
    for (int i = 0; i < 9; i++) begin
      total++;
      exp_v = {1'b1, 1'b0, ((i % 3) == 2), 1'b0, 4'(i % 3)};
      if (obs !== exp_v) $display("FAIL periodic[%0d] obs=%b exp=%b", i, obs, exp_v);
      else pass_cnt++;
      // start while running is ignored
      start = (i == 4);
      step();
    end
    start = 1'b0;
    stop  = 1'b1;
    step();
    stop  = 1'b0;
    total++;
    exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
    if (obs !== exp_v) $display("FAIL periodic_stop obs=%b exp=%b", obs, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_hold();
    configure(4'd5, 1'b0);
    do_start();
    step();
    step();
    total++;
    exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 4'd2};
    if (obs !== exp_v) $display("FAIL hold_pre obs=%b exp=%b", obs, exp_v);
    else pass_cnt++;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (obs !== exp_v) $display("FAIL hold_frozen[%0d] obs=%b exp=%b", i, obs, exp_v);
      else pass_cnt++;
    end
    hold = 1'b0;
    step();
    total++;
    if (obs !== exp_v) $display("FAIL hold_resume obs=%b exp=%b", obs, exp_v);
    else pass_cnt++;
    for (int i = 3; i <= 5; i++) begin
      step();
      total++;
      exp_v = {1'b1, 1'b0, (i == 5), 1'b0, 4'(i)};
      if (obs !== exp_v) $display("FAIL hold_count[%0d] obs=%b exp=%b", i, obs, exp_v);
      else pass_cnt++;
    end
    step();
    total++;
    exp_v = {1'b0, 1'b1, 1'b0, 1'b1, 4'd5};
    if (obs !== exp_v) $display("FAIL hold_done obs=%b exp=%b", obs, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_stop_priority();
    configure(4'd15, 1'b1);
    do_start();
    for (int i = 0; i < 9; i++) step();
    total++;
    exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 4'd9};
    if (obs !== exp_v) $display("FAIL stop_pre obs=%b exp=%b", obs, exp_v);
    else pass_cnt++;
    stop = 1'b1;
    hold = 1'b1;
    step();
    stop = 1'b0;
    hold = 1'b0;
    total++;
    exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
    if (obs !== exp_v) $display("FAIL stop_over_hold obs=%b exp=%b", obs, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_cfg_same_edge();
    cfg_valid    = 1'b1;
    cfg_limit    = 4'd1;
    cfg_periodic = 1'b0;
    start        = 1'b1;
    step();
    start        = 1'b0;
    // a different config held during RUN must not be taken
    cfg_limit    = 4'd7;
    cfg_periodic = 1'b1;
    total++;
    exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    if (obs !== exp_v) $display("FAIL cfgse_c0 obs=%b exp=%b", obs, exp_v);
    else pass_cnt++;
    step();
    total++;
    exp_v = {1'b1, 1'b0, 1'b1, 1'b0, 4'd1};
    if (obs !== exp_v) $display("FAIL cfgse_c1 obs=%b exp=%b", obs, exp_v);
    else pass_cnt++;
    step();
    cfg_valid = 1'b0;
    total++;
    exp_v = {1'b0, 1'b1, 1'b0, 1'b1, 4'd1};
    if (obs !== exp_v) $display("FAIL cfgse_done obs=%b exp=%b", obs, exp_v);
    else pass_cnt++;
    do_start();
    step();
    total++;
    exp_v = {1'b1, 1'b0, 1'b1, 1'b0, 4'd1};
    if (obs !== exp_v) $display("FAIL cfgse_rerun obs=%b exp=%b", obs, exp_v);
    else pass_cnt++;
    step();
    total++;
    exp_v = {1'b0, 1'b1, 1'b0, 1'b1, 4'd1};
    if (obs !== exp_v) $display("FAIL cfgse_rerun_done obs=%b exp=%b", obs, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_limit_zero();
    configure(4'd0, 1'b1);
    do_start();
    exp_v = {1'b1, 1'b0, 1'b1, 1'b0, 4'd0};
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs !== exp_v) $display("FAIL l0_periodic[%0d] obs=%b exp=%b", i, obs, exp_v);
      else pass_cnt++;
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    configure(4'd0, 1'b0);
    do_start();
    total++;
    if (obs !== exp_v) $display("FAIL l0_oneshot_run obs=%b exp=%b", obs, exp_v);
    else pass_cnt++;
    step();
    total++;
    exp_v = {1'b0, 1'b1, 1'b0, 1'b1, 4'd0};
    if (obs !== exp_v) $display("FAIL l0_oneshot_done obs=%b exp=%b", obs, exp_v);
    else pass_cnt++;
    step();
    total++;
    exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
    if (obs !== exp_v) $display("FAIL l0_oneshot_after obs=%b exp=%b", obs, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    configure(4'd9, 1'b1);
    do_start();
    for (int i = 0; i < 7; i++) step();
    total++;
    exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 4'd7};
    if (obs !== exp_v) $display("FAIL areset_pre obs=%b exp=%b", obs, exp_v);
    else pass_cnt++;
    #3;
    reset = 1'b1;
    #1;
    total++;
    exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
    if (obs !== exp_v) $display("FAIL areset_now obs=%b exp=%b", obs, exp_v);
    else pass_cnt++;
    #2;
    reset = 1'b0;
    step();
    total++;
    if (obs !== exp_v) $display("FAIL areset_no_done obs=%b exp=%b", obs, exp_v);
    else pass_cnt++;
    // default config: limit 15, one-shot (also exercises 15 without wrap)
    do_start();
    for (int i = 0; i < 16; i++) begin
      total++;
      exp_v = {1'b1, 1'b0, (i == 15), 1'b0, 4'(i)};
      if (obs !== exp_v) $display("FAIL areset_run[%0d] obs=%b exp=%b", i, obs, exp_v);
      else pass_cnt++;
      step();
    end
    total++;
    exp_v = {1'b0, 1'b1, 1'b0, 1'b1, 4'd15};
    if (obs !== exp_v) $display("FAIL areset_done obs=%b exp=%b", obs, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_wrap_full();
    configure(4'd15, 1'b1);
    do_start();
    for (int i = 0; i < 15; i++) step();
    total++;
    exp_v = {1'b1, 1'b0, 1'b1, 1'b0, 4'd15};
    if (obs !== exp_v) $display("FAIL wrap_top obs=%b exp=%b", obs, exp_v);
    else pass_cnt++;
    step();
    total++;
    exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    if (obs !== exp_v) $display("FAIL wrap_zero obs=%b exp=%b", obs, exp_v);
    else pass_cnt++;
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  initial begin
    pass_cnt     = 0;
    total        = 0;
    reset        = 1'b1;
    cfg_valid    = 1'b0;
    cfg_limit    = 4'd0;
    cfg_periodic = 1'b0;
    start        = 1'b0;
    hold         = 1'b0;
    stop         = 1'b0;
    test_reset();
    test_oneshot();
    test_periodic();
    test_hold();
    test_stop_priority();
    test_cfg_same_edge();
    test_limit_zero();
    test_wrap_full();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog obs=%b exp=finished", obs);
    $fatal(1, "timeout");
  end

endmodule
